// File: rtl/alu_pkg.sv
// Shared types for the accumulator ALU and its execution controller.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int NUM_REGS  = 4;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LD  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_NOT = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e              op;
    logic                 st;
    logic                 src;
    logic [1:0]           idx;
    logic [ALU_WIDTH-1:0] imm;
  } alu_instr_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: A is the accumulator, B the fetched operand.
// SUB reports borrow on co; only ADD/SUB produce co/ov.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  alu_op_e          op,
  input  logic             ci,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ov
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] cin_ext;

  assign cin_ext = {{WIDTH{1'b0}}, ci};

  always_comb begin
    sum    = '0;
    result = in_a;
    co     = 1'b0;
    ov     = 1'b0;
    unique case (op)
      OP_NOP: result = in_a;
      OP_LD:  result = in_b;
      OP_ADD: begin
        sum    = {1'b0, in_a} + {1'b0, in_b} + cin_ext;
        result = sum[WIDTH-1:0];
        co     = sum[WIDTH];
        ov     = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                 (result[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        sum    = {1'b0, in_a} - {1'b0, in_b} - cin_ext;
        result = sum[WIDTH-1:0];
        co     = sum[WIDTH];
        ov     = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                 (result[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_NOT: result = ~in_a;
      OP_AND: result = in_a & in_b;
      OP_OR:  result = in_a | in_b;
      OP_XOR: result = in_a ^ in_b;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Accumulator execution controller: S1 operand fetch, execute, result beat.
// ALU_CTRL_CARRY_CHAIN_EN feeds C into ADD/SUB carry-in.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_st,
  input  logic             in_src,
  input  logic [1:0]       in_idx,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_co,
  output logic             out_ov,
  output logic             flag_c,
  output logic             flag_v
);

  logic [WIDTH-1:0] rf [NUM_REGS];
  logic [WIDTH-1:0] acc;
  logic             c_q, v_q;

  logic             s1_valid;
  alu_op_e          s1_op;
  logic             s1_st;
  logic [1:0]       s1_idx;
  logic [WIDTH-1:0] s1_b;

  logic             s1_is_nop, exec_en, accept;
  logic [WIDTH-1:0] reg_b, fetch_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ci, alu_co, alu_ov;

  assign s1_is_nop = !s1_st && (s1_op == OP_NOP);
  assign exec_en   = s1_valid &&
                     (s1_is_nop || !out_valid || out_ready);
  assign in_ready  = !s1_valid || exec_en;
  assign accept    = in_valid && in_ready;

  // A store retiring this cycle has not reached rf yet.
  assign reg_b = (s1_valid && s1_st && exec_en &&
                  s1_idx == in_idx) ? acc : rf[in_idx];
  assign fetch_b = in_src ? reg_b : in_imm;

`ifdef ALU_CTRL_CARRY_CHAIN_EN
  assign alu_ci = (s1_op == OP_ADD || s1_op == OP_SUB) ? c_q : 1'b0;
`else
  assign alu_ci = 1'b0;
`endif

  alu #(.WIDTH(WIDTH)) u_alu (
    .in_a   (acc),
    .in_b   (s1_b),
    .op     (s1_op),
    .ci     (alu_ci),
    .result (alu_res),
    .co     (alu_co),
    .ov     (alu_ov)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      acc        <= '0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      s1_valid   <= 1'b0;
      s1_op      <= OP_NOP;
      s1_st      <= 1'b0;
      s1_idx     <= '0;
      s1_b       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_co     <= 1'b0;
      out_ov     <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= alu_op_e'(in_op);
        s1_st    <= in_st;
        s1_idx   <= in_idx;
        s1_b     <= fetch_b;
      end else if (exec_en) begin
        s1_valid <= 1'b0;
      end

      if (exec_en && !s1_is_nop) begin
        out_valid <= 1'b1;
        if (s1_st) begin
          rf[s1_idx] <= acc;
          out_result <= acc;
          out_co     <= c_q;
          out_ov     <= v_q;
        end else begin
          acc        <= alu_res;
          c_q        <= alu_co;
          v_q        <= alu_ov;
          out_result <= alu_res;
          out_co     <= alu_co;
          out_ov     <= alu_ov;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign flag_c = c_q;
  assign flag_v = v_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl with an in-order architectural model.
module tb_alu_ctrl;
  import alu_pkg::*;

`ifdef ALU_CTRL_CARRY_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0;
  logic       in_ready;
  logic [2:0] in_op = 0;
  logic       in_st = 0;
  logic       in_src = 0;
  logic [1:0] in_idx = 0;
  logic [7:0] in_imm = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [7:0] out_result;
  logic       out_co, out_ov, flag_c, flag_v;

  alu_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_st(in_st), .in_src(in_src),
    .in_idx(in_idx), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_co(out_co), .out_ov(out_ov),
    .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
  } beat_t;

  beat_t q[$];
  int errors = 0;
  int checks = 0;
  bit rand_done;

  logic [7:0] m_acc;
  logic       m_c, m_v;
  logic [7:0] m_rf [4];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_c = 0; m_v = 0;
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
  endfunction

  // Architectural meaning of one instruction, executed in program order.
  function automatic void model(alu_instr_t i);
    int a, b, cin, sa, sb, s, ss;
    beat_t e;
    if (i.st) begin
      m_rf[i.idx] = m_acc;
      e = '{m_acc, m_c, m_v};
      q.push_back(e);
      return;
    end
    if (i.op == OP_NOP) return;
    a = int'(m_acc);
    b = i.src ? int'(m_rf[i.idx]) : int'(i.imm);
    sa = a > 127 ? a - 256 : a;
    sb = b > 127 ? b - 256 : b;
    cin = (CHAIN && (i.op == OP_ADD || i.op == OP_SUB)) ? int'(m_c) : 0;
    s = 0; ss = 0;
    m_c = 0; m_v = 0;
    case (i.op)
      OP_LD:  s = b;
      OP_ADD: begin
        s = a + b + cin; ss = sa + sb + cin;
        m_c = s > 255; m_v = ss > 127 || ss < -128;
      end
      OP_SUB: begin
        s = a - b - cin; ss = sa - sb - cin;
        m_c = s < 0; m_v = ss > 127 || ss < -128;
      end
      OP_NOT: s = 255 - a;
      OP_AND: s = a & b;
      OP_OR:  s = a | b;
      OP_XOR: s = a ^ b;
      default: s = a;
    endcase
    m_acc = 8'((s + 512) % 256);
    e = '{m_acc, m_c, m_v};
    q.push_back(e);
  endfunction

  function automatic alu_instr_t mk(alu_op_e op, bit st, bit src,
                                    int idx, int imm);
    alu_instr_t i;
    i.op = op; i.st = st; i.src = src;
    i.idx = 2'(idx); i.imm = 8'(imm);
    return i;
  endfunction

  task automatic issue(alu_instr_t i);
    int n = 0;
    bit ok = 0;
    model(i);
    in_valid = 1; in_op = i.op; in_st = i.st;
    in_src = i.src; in_idx = i.idx; in_imm = i.imm;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      n++;
      if (!ok && n > 200) begin
        $display("FAIL issue_timeout: got in_ready 0 expected 1");
        $fatal(1, "stalled");
      end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_pending", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    beat_t e;
    alu_instr_t ri;
    model_reset();

    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
          if (q.size() == 0) begin
            chk("spurious_beat", {out_result, out_co, out_ov}, 0);
            errors += (out_result == 0 && !out_co && !out_ov) ? 1 : 0;
          end else begin
            e = q[0];
            chk("beat", {out_result, out_co, out_ov}, {e.r, e.c, e.v});
            if (out_ready) void'(q.pop_front());
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_flags", {flag_c, flag_v}, 0);
    @(posedge clk); #1;

    // signed overflow into 0x80
    issue(mk(OP_LD, 0, 0, 0, 8'h7F));
    issue(mk(OP_ADD, 0, 0, 0, 8'h01));
    drain();
    chk("ovf_flag_v", flag_v, 1);
    chk("ovf_flag_c", flag_c, 0);

    // carry chain
    issue(mk(OP_LD, 0, 0, 0, 8'hFF));
    issue(mk(OP_ADD, 0, 0, 0, 8'h01));
    issue(mk(OP_ADD, 0, 0, 0, 8'h00));
    drain();
    chk("chain_acc", out_result, CHAIN ? 8'h01 : 8'h00);
    chk("chain_flag_c", flag_c, 0);

    // store forwarding
    issue(mk(OP_LD, 0, 0, 0, 8'h3C));
    issue(mk(OP_NOP, 1, 0, 1, 0));
    issue(mk(OP_ADD, 0, 1, 1, 0));
    issue(mk(OP_LD, 0, 1, 1, 0));
    drain();
    chk("fwd_reload", out_result, 8'h3C);

    // backpressure with three ALU ops
    fork
      begin
        issue(mk(OP_LD, 0, 0, 0, 8'h05));
        issue(mk(OP_ADD, 0, 0, 0, 8'h07));
        issue(mk(OP_XOR, 0, 0, 0, 8'hF0));
      end
      begin
        out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain();

    // NOP produces no beat and keeps flags
    issue(mk(OP_LD, 0, 0, 0, 8'h11));
    issue(mk(OP_NOP, 0, 0, 0, 0));
    issue(mk(OP_XOR, 0, 0, 0, 8'h01));
    drain();
    chk("nop_result", out_result, 8'h10);

    // reset with S1 and output register occupied
    issue(mk(OP_LD, 0, 0, 0, 8'h5A));
    issue(mk(OP_NOP, 1, 0, 0, 0));
    drain();
    out_ready = 0;
    issue(mk(OP_LD, 0, 0, 0, 8'h22));
    issue(mk(OP_ADD, 0, 0, 0, 8'h01));
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    model_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1;
    issue(mk(OP_ADD, 0, 1, 0, 0));
    drain();
    chk("mid_rst_r0", out_result, 0);

    // random stream with random backpressure and gaps
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          ri = mk(alu_op_e'($urandom_range(0, 7)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), $urandom_range(0, 255));
          issue(ri);
          repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    drain();
    chk("rand_flags", {flag_c, flag_v}, {m_c, m_v});
    chk("rand_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
